// File: rtl/atm_pkg.sv
// Shared definitions for the ATM balance arbiter: FSM state encoding and
// transaction-type codes used by the arbiter top and its requesters.
package atm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      UPDATE = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic DEPOSITO = 1'b0;
   localparam logic RETIRO   = 1'b1;

endpackage

// File: rtl/atm_rr_arbiter.sv
// Combinational round-robin pick: searches req_valid upward from rr_ptr,
// wrapping at N_REQ, and reports the first set requester.
module atm_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [IDX_W-1:0] winner,
   output logic             any_valid
);

   int cand;

   // First valid requester at or after rr_ptr, modulo N_REQ.
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      cand      = 0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!any_valid && req_valid[cand[IDX_W-1:0]]) begin
            any_valid = 1'b1;
            winner    = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/atm_balance_arbiter.sv
// Single-writer arbiter for the shared account balance. Requests from N_REQ
// ATM front-ends are granted round-robin and sequenced IDLE -> CHECK ->
// UPDATE -> RESP. Optional macro LIMITE_RETIRO_EN adds a per-transaction
// withdrawal limit (MAX_RETIRO) checked ahead of the funds check.
//
// Handshake: a requester raises req_valid[i] with req_tipo[i]/req_monto held
// stable until ack[i] pulses (one cycle after the sampling edge). The result
// arrives as a one-cycle done[i] pulse with exactly one status flag set.
// req_valid must be dropped by the cycle after done, otherwise it counts as
// a new request. Inputs are only looked at while the FSM is IDLE.
module atm_balance_arbiter
   import atm_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int MONTO_W      = 32,
   parameter int BAL_W        = 64,
   parameter int INIT_BALANCE = 50000,
   parameter int MAX_RETIRO   = 20000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ-1:0]         req_tipo,
   input  logic [N_REQ*MONTO_W-1:0] req_monto,
   output logic [N_REQ-1:0]         ack,
   output logic [N_REQ-1:0]         done,
   output logic                     ok,
   output logic                     fondos_insuficientes,
   output logic                     overflow,
   output logic                     limite_excedido,
   output logic [BAL_W-1:0]         balance,
   output logic                     busy,
   output logic [1:0]               state_dbg
);

   localparam int IDX_W = $clog2(N_REQ);

   // Elaboration-time sanity checks on the configuration.
   if (BAL_W <= MONTO_W || N_REQ < 2 || N_REQ > 8 || MAX_RETIRO < 0) begin : g_bad_params
      $error("atm_balance_arbiter: illegal parameter combination");
   end

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   idx_q;
   logic               tipo_q;
   logic [MONTO_W-1:0] monto_q;
   logic               fondos_q;
   logic               over_q;
   logic               lim_q;

   logic [IDX_W-1:0]   winner;
   logic               any_valid;

   logic [BAL_W-1:0]   monto_ext;
   logic [BAL_W:0]     sum_c;
   logic               lim_c;
   logic               fondos_c;
   logic               over_c;

   atm_rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .winner    (winner),
      .any_valid (any_valid)
   );

   assign busy      = (state != IDLE);
   assign state_dbg = state;

   // Evaluate the latched request against the current balance; the
   // deposit sum carries one extra bit so overflow is visible.
   always_comb begin
      monto_ext = {{(BAL_W-MONTO_W){1'b0}}, monto_q};
      sum_c     = {1'b0, balance} + {1'b0, monto_ext};
`ifdef LIMITE_RETIRO_EN
      lim_c     = (tipo_q == RETIRO) && (monto_q > MONTO_W'(MAX_RETIRO));
`else
      lim_c     = 1'b0;
`endif
      fondos_c  = (tipo_q == RETIRO) && !lim_c && (monto_ext > balance);
      over_c    = (tipo_q == DEPOSITO) && sum_c[BAL_W];
   end

   // Transaction sequencer with registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                <= IDLE;
         balance              <= BAL_W'(INIT_BALANCE);
         rr_ptr               <= '0;
         idx_q                <= '0;
         tipo_q               <= DEPOSITO;
         monto_q              <= '0;
         fondos_q             <= 1'b0;
         over_q               <= 1'b0;
         lim_q                <= 1'b0;
         ack                  <= '0;
         done                 <= '0;
         ok                   <= 1'b0;
         fondos_insuficientes <= 1'b0;
         overflow             <= 1'b0;
         limite_excedido      <= 1'b0;
      end else begin
         ack                  <= '0;
         done                 <= '0;
         ok                   <= 1'b0;
         fondos_insuficientes <= 1'b0;
         overflow             <= 1'b0;
         limite_excedido      <= 1'b0;
         case (state)
            IDLE: begin
               if (any_valid) begin
                  idx_q   <= winner;
                  tipo_q  <= req_tipo[winner];
                  monto_q <= req_monto[winner*MONTO_W +: MONTO_W];
                  ack     <= N_REQ'(1) << winner;
                  state   <= CHECK;
               end
            end
            CHECK: begin
               fondos_q <= fondos_c;
               over_q   <= over_c;
               lim_q    <= lim_c;
               state    <= UPDATE;
            end
            UPDATE: begin
               if (!(fondos_q || over_q || lim_q)) begin
                  if (tipo_q == RETIRO) balance <= balance - monto_ext;
                  else                  balance <= sum_c[BAL_W-1:0];
               end
               state <= RESP;
            end
            RESP: begin
               done                 <= N_REQ'(1) << idx_q;
               ok                   <= !(fondos_q || over_q || lim_q);
               fondos_insuficientes <= fondos_q;
               overflow             <= over_q;
               limite_excedido      <= lim_q;
               rr_ptr               <= (int'(idx_q) == N_REQ-1) ? '0 : idx_q + 1'b1;
               state                <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_atm_balance_arbiter.sv
// Self-checking bench for atm_balance_arbiter (default parameters).
module tb_atm_balance_arbiter;

   localparam int N_REQ   = 4;
   localparam int MONTO_W = 32;
   localparam int BAL_W   = 64;
   localparam int EW      = 2 + 4 + BAL_W;  // {idx, ok, fondos, overflow, limite, balance}

   logic                     clk;
   logic                     rst;
   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ-1:0]         req_tipo;
   logic [N_REQ*MONTO_W-1:0] req_monto;
   logic [N_REQ-1:0]         ack;
   logic [N_REQ-1:0]         done;
   logic                     ok;
   logic                     fondos_insuficientes;
   logic                     overflow;
   logic                     limite_excedido;
   logic [BAL_W-1:0]         balance;
   logic                     busy;
   logic [1:0]               state_dbg;

   logic [EW-1:0] exp_q[$];
   int            ack_q[$];
   int            ack_cyc[N_REQ];
   int            cyc;
   int            n_cmp;
   int            n_fail;

   atm_balance_arbiter dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_valid            (req_valid),
      .req_tipo             (req_tipo),
      .req_monto            (req_monto),
      .ack                  (ack),
      .done                 (done),
      .ok                   (ok),
      .fondos_insuficientes (fondos_insuficientes),
      .overflow             (overflow),
      .limite_excedido      (limite_excedido),
      .balance              (balance),
      .busy                 (busy),
      .state_dbg            (state_dbg)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [EW-1:0] mk(input int idx, input logic o, input logic fi,
                                        input logic ov, input logic le,
                                        input logic [BAL_W-1:0] bal);
      logic [1:0] i2;
      i2 = idx[1:0];
      return {i2, o, fi, ov, le, bal};
   endfunction

   task automatic chk(input string name, input logic [BAL_W-1:0] act, input logic [BAL_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor / scoreboard: compares ack and done pulses against expectations.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      logic [EW-1:0] a;
      int            di;
      int            ai;
      if (rst) begin
         if (ack != '0) begin
            n_cmp++;
            if (ack_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_ack: got %b expected none", ack);
            end else begin
               ai = ack_q.pop_front();
               if (ack != (4'b0001 << ai)) begin
                  n_fail++;
                  $display("FAIL ack_grant: got %b expected idx %0d", ack, ai);
               end
               ack_cyc[ai] = cyc;
            end
         end
         if (done != '0) begin
            di = 0;
            for (int i = 0; i < N_REQ; i++) if (done[i]) di = i;
            n_cmp++;
            if (!$onehot(done)) begin
               n_fail++;
               $display("FAIL done_onehot: got %b expected one-hot", done);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_done: got %b expected none", done);
            end else begin
               e = exp_q.pop_front();
               a = mk(di, ok, fondos_insuficientes, overflow, limite_excedido, balance);
               if (a !== e) begin
                  n_fail++;
                  $display("FAIL done_record: got idx=%0d flags=%b bal=%0d expected idx=%0d flags=%b bal=%0d",
                           a[EW-1:EW-2], a[EW-3:BAL_W], a[BAL_W-1:0],
                           e[EW-1:EW-2], e[EW-3:BAL_W], e[BAL_W-1:0]);
               end
               n_cmp++;
               if (cyc - ack_cyc[di] != 3) begin
                  n_fail++;
                  $display("FAIL done_latency: got %0d cycles after ack expected 3", cyc - ack_cyc[di]);
               end
            end
         end else begin
            n_cmp++;
            if ({ok, fondos_insuficientes, overflow, limite_excedido} != 4'b0000) begin
               n_fail++;
               $display("FAIL flags_idle: got %b expected 0000",
                        {ok, fondos_insuficientes, overflow, limite_excedido});
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b0;
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic wait_ack(input int i, output bit seen);
      seen = 1'b0;
      for (int n = 0; n < 12 && !seen; n++) begin
         @(negedge clk);
         if (ack[i]) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_fail++;
         $display("FAIL ack_timeout: got no ack expected ack[%0d]", i);
      end
   endtask

   task automatic drive(input int i, input logic tipo, input logic [MONTO_W-1:0] m);
      req_valid[i]                 = 1'b1;
      req_tipo[i]                  = tipo;
      req_monto[i*MONTO_W +: MONTO_W] = m;
   endtask

   // One transaction from requester i: issue, wait for ack, drop, drain.
   task automatic txn(input int i, input logic tipo, input logic [MONTO_W-1:0] m, input logic [EW-1:0] e);
      bit seen;
      ack_q.push_back(i);
      exp_q.push_back(e);
      @(negedge clk);
      drive(i, tipo, m);
      wait_ack(i, seen);
      req_valid[i] = 1'b0;
      wait_drain();
   endtask

   // All requesters deposit m at once; each drops on its own ack.
   task automatic all_deposit(input logic [MONTO_W-1:0] m, input logic [BAL_W-1:0] base, input logic [BAL_W-1:0] step);
      int n;
      for (int i = 0; i < N_REQ; i++) begin
         ack_q.push_back(i);
         exp_q.push_back(mk(i, 1'b1, 1'b0, 1'b0, 1'b0, base + step * (i + 1)));
      end
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) drive(i, 1'b0, m);
      n = 0;
      while (req_valid != '0 && n < 40) begin
         @(negedge clk);
         for (int i = 0; i < N_REQ; i++) if (ack[i]) req_valid[i] = 1'b0;
         n++;
      end
      n_cmp++;
      if (req_valid != '0) begin
         n_fail++;
         $display("FAIL rr_timeout: got pending %b expected 0000", req_valid);
         req_valid = '0;
      end
      wait_drain();
   endtask

   initial begin
      bit seen;
      n_cmp     = 0;
      n_fail    = 0;
      rst       = 1'b0;
      req_valid = '0;
      req_tipo  = '0;
      req_monto = '0;
      for (int i = 0; i < N_REQ; i++) ack_cyc[i] = 0;
      repeat (2) @(negedge clk);
      chk("reset_balance_in_reset", balance, 64'd50000);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_balance", balance, 64'd50000);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_state", {62'd0, state_dbg}, 64'd0);
      chk("reset_ack_done", {56'd0, ack, done}, 64'd0);

      // Single deposit, then insufficient funds from requester 2.
      txn(0, 1'b0, 32'd2000, mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd52000));
      chk("bal_after_deposit", balance, 64'd52000);
      txn(2, 1'b1, 32'd60000, mk(2, 1'b0, 1'b1, 1'b0, 1'b0, 64'd52000));
      chk("bal_after_nsf", balance, 64'd52000);

      // Strict rotation with all requesters valid.
      do_reset();
      all_deposit(32'd1, 64'd50000, 64'd1);
      chk("bal_after_rr", balance, 64'd50004);

      // Exact drain then zero deposit (rr_ptr=2 wraps round to requester 1).
      do_reset();
      txn(1, 1'b1, 32'd50000, mk(1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0));
      txn(1, 1'b0, 32'd0, mk(1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0));
      chk("bal_after_zero", balance, 64'd0);

      // Withdrawal limit behaviour.
      do_reset();
`ifdef LIMITE_RETIRO_EN
      txn(3, 1'b1, 32'd25000, mk(3, 1'b0, 1'b0, 1'b0, 1'b1, 64'd50000));
      txn(0, 1'b1, 32'd60000, mk(0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd50000));
`else
      txn(3, 1'b1, 32'd25000, mk(3, 1'b1, 1'b0, 1'b0, 1'b0, 64'd25000));
      txn(0, 1'b1, 32'd30000, mk(0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd25000));
`endif

      // Reset while the accepted deposit sits in UPDATE: no done, state cleared.
      ack_q.push_back(2);
      @(negedge clk);
      drive(2, 1'b0, 32'd1000);
      wait_ack(2, seen);
      req_valid[2] = 1'b0;
      @(posedge clk);
      #2;
      chk("mid_in_update", {62'd0, state_dbg}, 64'd2);
      rst = 1'b0;
      #1;
      chk("mid_reset_balance", balance, 64'd50000);
      chk("mid_reset_busy", {63'd0, busy}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      all_deposit(32'd0, 64'd50000, 64'd0);

      // Requester 1 pulses valid while busy and is never granted.
      ack_q.push_back(0);
      exp_q.push_back(mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd50005));
      @(negedge clk);
      drive(0, 1'b0, 32'd5);
      wait_ack(0, seen);
      req_valid[0] = 1'b0;
      drive(1, 1'b1, 32'd7);
      @(negedge clk);
      req_valid[1] = 1'b0;
      wait_drain();
      repeat (4) @(negedge clk);
      chk("bal_after_transient", balance, 64'd50005);
      chk("ack_q_empty", 64'(ack_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Absolute time guard.
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
